// File: rtl/sync_perf_record_arbiter_pkg.sv
// Shared sync-perf types: barrier id, emitted record layout and slot-index width.
// THREAD_NUMB defaults to 4 when the build does not provide it.
`ifndef THREAD_NUMB
`define THREAD_NUMB 4
`endif

package npu_synchronization_defines;

  localparam int THREAD_NUMB_P   = `THREAD_NUMB;
  localparam int SYNC_NUM_EVENTS = 2;
  localparam int SYNC_NUM_SLOTS  = SYNC_NUM_EVENTS * THREAD_NUMB_P;
  localparam int BARRIER_W       = 4;
  localparam int TILE_ID_W       = 8;
  localparam int SYNC_CNT_W      = 64;

  // Index widths never collapse to zero bits, even for a single thread/event.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int THREAD_ID_W = clog2_min1(THREAD_NUMB_P);
  localparam int EVENT_ID_W  = clog2_min1(SYNC_NUM_EVENTS);
  localparam int SLOT_IDX_W  = clog2_min1(SYNC_NUM_SLOTS);

  typedef logic [BARRIER_W-1:0] barrier_t;

  typedef struct packed {
    logic [TILE_ID_W-1:0]   tile_id;
    logic [THREAD_ID_W-1:0] thread_id;
    logic [EVENT_ID_W-1:0]  event_id;
    barrier_t               barrier_id;
    logic [SYNC_CNT_W-1:0]  count;
  } sync_perf_record_t;

endpackage

// File: rtl/sync_perf_record_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot grant starting at the priority pointer;
// the pointer advances to granted+1 only when the grant is accepted.
module rr_arbiter #(
  parameter int N     = 8,
  parameter int IDX_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N-1:0]     req,
  input  logic             accept,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_valid
);

  logic [IDX_W-1:0] ptr;

  always_comb begin
    int j;
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    j           = 0;
    for (int i = 0; i < N; i++) begin
      j = int'(ptr) + i;
      if (j >= N) j = j - N;
      if (!grant_valid && req[j]) begin
        grant_valid = 1'b1;
        grant[j]    = 1'b1;
        grant_idx   = IDX_W'(j);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr <= '0;
    end else if (accept && grant_valid) begin
      ptr <= (int'(grant_idx) == N - 1) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/sync_perf_record_arbiter.sv
// Collects closed perf-counter runs per (event, thread) slot and streams them out one record
// per cycle. Build with SYNC_PERF_DROP_CNT_EN to count overwritten records in drop_count.
//   state | meaning
//   IDLE  | no record presented, out_valid=0
//   HOLD  | out_record presented, waiting for out_ready
module sync_perf_record_arbiter
  import npu_synchronization_defines::*;
#(
  parameter int TILE_ID_PAR = 0,
  parameter int NUM_EVENTS  = 2,
  parameter int CNT_WIDTH   = 64
) (
  input  logic                                                 clk,
  input  logic                                                 reset,
  input  logic [NUM_EVENTS-1:0][`THREAD_NUMB-1:0]                rec_valid,
  input  logic [NUM_EVENTS-1:0][`THREAD_NUMB-1:0][CNT_WIDTH-1:0] rec_count,
  input  barrier_t [`THREAD_NUMB-1:0]                            rec_barrier_id,
  output logic                                                 out_valid,
  input  logic                                                 out_ready,
  output sync_perf_record_t                                    out_record,
  output logic [15:0]                                          drop_count
);

  localparam int NT        = `THREAD_NUMB;
  localparam int NUM_SLOTS = NUM_EVENTS * NT;
  localparam int IDX_W     = clog2_min1(NUM_SLOTS);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t                              state, state_next;
  logic [NUM_SLOTS-1:0]                rv_flat, pend, req_vec, grant, taken;
  logic [NUM_SLOTS-1:0][CNT_WIDTH-1:0] rc_flat;
  logic [CNT_WIDTH-1:0]                hold_count [NUM_SLOTS];
  barrier_t                            hold_bar   [NUM_SLOTS];
  logic [IDX_W-1:0]                    grant_idx;
  logic                                grant_valid, take, accept;
  sync_perf_record_t                   rec_next;

  assign rv_flat = rec_valid;
  assign rc_flat = rec_count;
  // A fresh pulse is requestable in its own cycle so an idle FSM emits it one cycle later.
  assign req_vec = pend | rv_flat;
  assign taken   = accept ? grant : '0;

  rr_arbiter #(.N(NUM_SLOTS), .IDX_W(IDX_W)) u_rr (
    .clk         (clk),
    .reset       (reset),
    .req         (req_vec),
    .accept      (accept),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  always_comb begin
    state_next = state;
    take       = (state == IDLE) || out_ready;
    accept     = take && grant_valid;
    out_valid  = (state == HOLD);
    if (accept)    state_next = HOLD;
    else if (take) state_next = IDLE;
  end

  always_comb begin
    rec_next           = '0;
    rec_next.tile_id   = TILE_ID_W'(TILE_ID_PAR);
    rec_next.thread_id = THREAD_ID_W'(int'(grant_idx) % NT);
    rec_next.event_id  = EVENT_ID_W'(int'(grant_idx) / NT);
    if (pend[grant_idx]) begin
      rec_next.count      = SYNC_CNT_W'(hold_count[grant_idx]);
      rec_next.barrier_id = hold_bar[grant_idx];
    end else begin
      rec_next.count      = SYNC_CNT_W'(rc_flat[grant_idx]);
      rec_next.barrier_id = rec_barrier_id[int'(grant_idx) % NT];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      out_record <= '0;
    end else begin
      state <= state_next;
      if (accept) out_record <= rec_next;
    end
  end

  // A pulse on a slot granted from its holding register stays pending behind the old record.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend <= '0;
      for (int s = 0; s < NUM_SLOTS; s++) begin
        hold_count[s] <= '0;
        hold_bar[s]   <= '0;
      end
    end else begin
      for (int s = 0; s < NUM_SLOTS; s++) begin
        if (rv_flat[s]) begin
          if (!(taken[s] && !pend[s])) begin
            pend[s]       <= 1'b1;
            hold_count[s] <= rc_flat[s];
            hold_bar[s]   <= rec_barrier_id[s % NT];
          end
        end else if (taken[s]) begin
          pend[s] <= 1'b0;
        end
      end
    end
  end

`ifdef SYNC_PERF_DROP_CNT_EN
  logic [NUM_SLOTS-1:0] ovw;
  logic [16:0]          drop_sum;

  assign ovw      = rv_flat & pend & ~taken;
  assign drop_sum = {1'b0, drop_count} + 17'($countones(ovw));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_count <= '0;
    end else begin
      drop_count <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
  end
`else
  assign drop_count = '0;
`endif

endmodule

// File: tb/tb_sync_perf_record_arbiter.sv
// Bench for sync_perf_record_arbiter: directed scenarios plus random traffic against a slot-list model.
module tb_sync_perf_record_arbiter;
  import npu_synchronization_defines::*;

  localparam int NT   = `THREAD_NUMB;
  localparam int NE   = 2;
  localparam int NS   = NE * NT;
  localparam int TILE = 3;

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic [NS-1:0]         rv = '0;
  logic [NS-1:0][63:0]   rc = '0;
  barrier_t [NT-1:0]     rb = '0;
  logic                  ready = 1'b0;
  logic                  out_valid;
  sync_perf_record_t     out_record;
  logic [15:0]           drop_count;

  bit                m_pend [NS];
  logic [63:0]       m_cnt  [NS];
  barrier_t          m_bar  [NS];
  bit                m_valid;
  sync_perf_record_t m_rec;
  int                m_ptr, m_drop;
  int                total = 0, bad = 0;
  sync_perf_record_t held;

  sync_perf_record_arbiter #(.TILE_ID_PAR(TILE), .NUM_EVENTS(NE), .CNT_WIDTH(64)) dut (
    .clk            (clk),
    .reset          (reset),
    .rec_valid      (rv),
    .rec_count      (rc),
    .rec_barrier_id (rb),
    .out_valid      (out_valid),
    .out_ready      (ready),
    .out_record     (out_record),
    .drop_count     (drop_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic sync_perf_record_t make_rec(input int slot, input logic [63:0] cnt, input barrier_t b);
    sync_perf_record_t r;
    r.tile_id    = TILE_ID_W'(TILE);
    r.thread_id  = THREAD_ID_W'(slot % NT);
    r.event_id   = EVENT_ID_W'(slot / NT);
    r.barrier_id = b;
    r.count      = cnt;
    return r;
  endfunction

  function automatic int exp_drop();
`ifdef SYNC_PERF_DROP_CNT_EN
    return m_drop;
`else
    return 0;
`endif
  endfunction

  task automatic model_reset();
    for (int s = 0; s < NS; s++) begin
      m_pend[s] = 0;
      m_cnt[s]  = '0;
      m_bar[s]  = '0;
    end
    m_valid = 0;
    m_rec   = '0;
    m_ptr   = 0;
    m_drop  = 0;
  endtask

  // One clock of the behavioural model, using the inputs currently driven.
  task automatic model_step();
    bit take;
    int g;
    take = !m_valid || ready;
    g = -1;
    if (take) begin
      for (int k = 0; k < NS; k++) begin
        int s;
        s = (m_ptr + k) % NS;
        if (g < 0 && (m_pend[s] || rv[s])) g = s;
      end
    end
    if (g >= 0) begin
      if (m_pend[g]) m_rec = make_rec(g, m_cnt[g], m_bar[g]);
      else           m_rec = make_rec(g, rc[g], rb[g % NT]);
      m_valid = 1;
      m_ptr   = (g + 1) % NS;
    end else if (take) begin
      m_valid = 0;
    end
    for (int s = 0; s < NS; s++) begin
      if (rv[s]) begin
        if (s == g && !m_pend[s]) begin
          // consumed directly in the cycle it arrived
        end else begin
          if (m_pend[s] && s != g) m_drop = (m_drop < 65535) ? m_drop + 1 : 65535;
          m_pend[s] = 1;
          m_cnt[s]  = rc[s];
          m_bar[s]  = rb[s % NT];
        end
      end else if (s == g) begin
        m_pend[s] = 0;
      end
    end
  endtask

  task automatic cmp_outputs();
    chk("out_valid", 128'(out_valid), 128'(m_valid));
    if (m_valid) chk("out_record", 128'(out_record), 128'(m_rec));
    chk("drop_count", 128'(drop_count), 128'(exp_drop()));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    cmp_outputs();
    rv = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    rv    = '0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    chk("rst_valid", 128'(out_valid), 128'(0));
    chk("rst_record", 128'(out_record), 128'(0));
    chk("rst_drop", 128'(drop_count), 128'(0));
    reset = 1'b0;
  endtask

  initial begin
    do_reset();

    // single pulse on thread 1 / event 0
    ready = 1'b1; rc[1] = 64'd37; rb[1] = 4'd5; rv[1] = 1'b1;
    tick();
    chk("t030_valid", 128'(out_valid), 128'(1));
    chk("t030_rec", 128'(out_record), 128'(make_rec(1, 64'd37, 4'd5)));
    tick();
    chk("t030_idle", 128'(out_valid), 128'(0));

    // every slot at once drains in slot order
    do_reset();
    ready = 1'b1;
    for (int t = 0; t < NT; t++) rb[t] = barrier_t'(t + 8);
    for (int s = 0; s < NS; s++) begin
      rv[s] = 1'b1;
      rc[s] = 64'(100 + s);
    end
    for (int s = 0; s < NS; s++) begin
      tick();
      chk("t031_order", 128'(out_record), 128'(make_rec(s, 64'(100 + s), barrier_t'((s % NT) + 8))));
    end
    tick();
    chk("t031_idle", 128'(out_valid), 128'(0));
    chk("t031_drop", 128'(drop_count), 128'(0));

    // back-pressure: stable record, overwrite of a pending slot
    do_reset();
    ready = 1'b0;
    rc[2] = 64'd50; rb[2] = 4'd2; rv[2] = 1'b1;
    rc[3] = 64'd60; rb[3] = 4'd7; rv[3] = 1'b1;
    tick();
    chk("t032_first", 128'(out_record), 128'(make_rec(2, 64'd50, 4'd2)));
    held = out_record;
    for (int i = 0; i < 10; i++) begin
      if (i == 4) begin
        rv[3] = 1'b1;
        rc[3] = 64'd61;
      end
      tick();
      chk("t032_stable", 128'(out_record), 128'(held));
    end
    ready = 1'b1;
    tick();
    chk("t032_newer", 128'(out_record), 128'(make_rec(3, 64'd61, 4'd7)));
`ifdef SYNC_PERF_DROP_CNT_EN
    chk("t032_drop", 128'(drop_count), 128'(1));
`else
    chk("t035_drop", 128'(drop_count), 128'(0));
`endif

    // pulse on the slot granted in the same cycle
    do_reset();
    ready = 1'b0;
    rb[0] = 4'd1; rb[1] = 4'd2;
    rc[0] = 64'd10; rv[0] = 1'b1;
    rc[1] = 64'd11; rv[1] = 1'b1;
    tick();
    chk("t033_slot0", 128'(out_record), 128'(make_rec(0, 64'd10, 4'd1)));
    ready = 1'b1;
    rc[1] = 64'd12; rv[1] = 1'b1;
    tick();
    chk("t033_old", 128'(out_record), 128'(make_rec(1, 64'd11, 4'd2)));
    tick();
    chk("t033_new", 128'(out_record), 128'(make_rec(1, 64'd12, 4'd2)));
    chk("t033_drop", 128'(drop_count), 128'(0));
    tick();

    // reset in HOLD with three slots pending
    do_reset();
    ready = 1'b0;
    for (int s = 0; s < NS; s += 2) begin
      rv[s] = 1'b1;
      rc[s] = 64'(200 + s);
    end
    tick();
    tick();
    chk("t034_hold", 128'(out_valid), 128'(1));
    reset = 1'b1;
    #1;
    chk("t034_async", 128'(out_valid), 128'(0));
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t034_quiet", 128'(out_valid), 128'(0));
    end
    rb[0] = 4'd3; rb[1] = 4'd4;
    rc[0] = 64'd300; rv[0] = 1'b1;
    rc[5] = 64'd305; rv[5] = 1'b1;
    tick();
    chk("t034_ptr0", 128'(out_record), 128'(make_rec(0, 64'd300, 4'd3)));
    tick();
    chk("t034_next", 128'(out_record), 128'(make_rec(5, 64'd305, 4'd4)));
    tick();

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      for (int s = 0; s < NS; s++) begin
        rv[s] = ($urandom_range(0, 3) == 0);
        rc[s] = {$urandom, $urandom};
      end
      for (int t = 0; t < NT; t++) rb[t] = barrier_t'($urandom_range(0, 15));
      ready = ($urandom_range(0, 9) < 7);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
